// File: rtl/game_tick_engine.sv
// game_tick_engine: jump-the-obstacle lane, advanced once per game tick.
// Holds obstacle row, airtime, score and the IDLE/RUN/OVER game FSM.
module game_tick_engine #(
   parameter int AIR_TICKS = 3,
   parameter int MIN_GAP   = 4,
   parameter int SCORE_MAX = 999
) (
   input  logic        CLOCK_50,
   input  logic        RESET,
   input  logic        PULSE_EARLY,
   input  logic        PULSE,
   input  logic        START,
   input  logic        JUMP,
   output logic [15:0] OBSTACLES,
   output logic        AIRBORNE,
   output logic [9:0]  SCORE,
   output logic [1:0]  STATE,
   output logic        TICK_DONE
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      OVER = 2'b10
   } state_t;

   localparam logic [2:0] AIR_W   = 3'(AIR_TICKS);
   localparam logic [4:0] GAP_MIN = 5'(MIN_GAP);
   localparam logic [9:0] S_MAX   = 10'(SCORE_MAX);

   state_t      state, state_d;
   logic [15:0] obs, obs_d, obs_t;
   logic [2:0]  air, air_d, air_t;
   logic [9:0]  score, score_d;
   logic [3:0]  gap, gap_d, gap_t;
   logic [7:0]  lfsr, lfsr_d, lfsr_t;
   logic        jreq, jreq_d;
   logic        start_q;
   logic        tick_done, tick_d;
   logic        start_edge, spawn, hit, clr;

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         state     <= IDLE;
         obs       <= '0;
         air       <= '0;
         score     <= '0;
         gap       <= '0;
         lfsr      <= 8'hA5;
         jreq      <= 1'b0;
         start_q   <= 1'b0;
         tick_done <= 1'b0;
      end else begin
         state     <= state_d;
         obs       <= obs_d;
         air       <= air_d;
         score     <= score_d;
         gap       <= gap_d;
         lfsr      <= lfsr_d;
         jreq      <= jreq_d;
         start_q   <= START;
         tick_done <= tick_d;
      end
   end

   // Tick candidates, all derived from the current register values
   always_comb begin
      start_edge = START & ~start_q;
      spawn = (lfsr[2:0] == 3'd0) && ({1'b0, gap} >= GAP_MIN);
      if (spawn)
         gap_t = 4'd0;
      else if (gap == 4'd15)
         gap_t = 4'd15;
      else
         gap_t = gap + 4'd1;
      obs_t = {spawn, obs[15:1]};
      if (air == 3'd0 && jreq)
         air_t = AIR_W;
      else if (air != 3'd0)
         air_t = air - 3'd1;
      else
         air_t = 3'd0;
      hit    = obs_t[0] && (air_t == 3'd0);
      clr    = obs_t[0] && (air_t != 3'd0);
      lfsr_t = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   always_comb begin
      state_d = state;
      obs_d   = obs;
      air_d   = air;
      score_d = score;
      gap_d   = gap;
      lfsr_d  = lfsr;
      jreq_d  = jreq;
      tick_d  = 1'b0;
      unique case (state)
         IDLE, OVER: begin
            // A tick coinciding with the start edge is dropped
            if (start_edge) begin
               state_d = RUN;
               obs_d   = '0;
               air_d   = '0;
               score_d = '0;
               gap_d   = '0;
               jreq_d  = 1'b0;
            end
         end
         RUN: begin
            if (PULSE) begin
               tick_d = 1'b1;
               jreq_d = 1'b0;
               lfsr_d = lfsr_t;
               gap_d  = gap_t;
               obs_d  = obs_t;
               air_d  = air_t;
               if (hit)
                  state_d = OVER;
               else if (clr && score < S_MAX)
                  score_d = score + 10'd1;
            end else if (PULSE_EARLY && JUMP) begin
               jreq_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign OBSTACLES = obs;
   assign AIRBORNE  = (air != 3'd0);
   assign SCORE     = score;
   assign STATE     = state;
   assign TICK_DONE = tick_done;

endmodule

// File: tb/tb_game_tick_engine.sv
// tb_game_tick_engine: directed bench for game_tick_engine with a
// cycle-level reference model checked at every falling clock edge.
module tb_game_tick_engine;

   localparam int SMAX = 5;

   logic        CLOCK_50 = 1'b0;
   logic        RESET, PULSE_EARLY, PULSE, START, JUMP;
   logic [15:0] OBSTACLES;
   logic        AIRBORNE;
   logic [9:0]  SCORE;
   logic [1:0]  STATE;
   logic        TICK_DONE;

   int checks = 0;
   int errors = 0;

   game_tick_engine #(
      .AIR_TICKS(3),
      .MIN_GAP  (4),
      .SCORE_MAX(SMAX)
   ) dut (
      .CLOCK_50   (CLOCK_50),
      .RESET      (RESET),
      .PULSE_EARLY(PULSE_EARLY),
      .PULSE      (PULSE),
      .START      (START),
      .JUMP       (JUMP),
      .OBSTACLES  (OBSTACLES),
      .AIRBORNE   (AIRBORNE),
      .SCORE      (SCORE),
      .STATE      (STATE),
      .TICK_DONE  (TICK_DONE)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   logic [1:0]  m_state;
   logic [15:0] m_obs;
   logic [2:0]  m_air;
   logic [9:0]  m_score;
   logic [3:0]  m_gap;
   logic [7:0]  m_lfsr;
   logic        m_jreq, m_sq, m_td;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      m_state = 2'b00; m_obs = '0; m_air = '0; m_score = '0;
      m_gap = '0; m_lfsr = 8'hA5; m_jreq = 0; m_sq = 0; m_td = 0;
   endtask

   // Predict the effect of the next rising edge from current inputs
   task automatic m_step();
      logic        se, sp;
      logic [15:0] o;
      logic [2:0]  a;
      se = START && !m_sq;
      m_sq = START;
      m_td = 0;
      if (m_state != 2'b01) begin
         if (se) begin
            m_state = 2'b01; m_obs = '0; m_air = '0;
            m_score = '0; m_gap = '0; m_jreq = 0;
         end
      end else if (PULSE) begin
         sp = (m_lfsr[2:0] == 3'd0) && (m_gap >= 4'd4);
         o = {sp, m_obs[15:1]};
         a = (m_air == 0 && m_jreq) ? 3'd3 :
             (m_air != 0 ? m_air - 3'd1 : 3'd0);
         m_gap = sp ? 4'd0 : (m_gap == 4'd15 ? 4'd15 : m_gap + 4'd1);
         m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
         m_td = 1; m_jreq = 0;
         if (o[0] && a == 0) m_state = 2'b10;
         else if (o[0] && m_score < SMAX) m_score = m_score + 10'd1;
         m_obs = o; m_air = a;
      end else if (PULSE_EARLY && JUMP) begin
         m_jreq = 1;
      end
   endtask

   task automatic check_all();
      chk("state", 32'(STATE), 32'(m_state));
      chk("obstacles", 32'(OBSTACLES), 32'(m_obs));
      chk("airborne", 32'(AIRBORNE), 32'(m_air != 0));
      chk("score", 32'(SCORE), 32'(m_score));
      chk("tick_done", 32'(TICK_DONE), 32'(m_td));
   endtask

   task automatic cyc();
      m_step();
      @(negedge CLOCK_50);
      check_all();
   endtask

   // One game tick: early strobe, 15 clocks later the tick, one clock after
   task automatic tick(input logic jmp, input logic coincide);
      if (coincide) begin
         PULSE_EARLY = 1; PULSE = 1; JUMP = jmp;
         cyc();
         PULSE_EARLY = 0; PULSE = 0; JUMP = 0;
      end else begin
         PULSE_EARLY = 1; JUMP = jmp;
         cyc();
         PULSE_EARLY = 0; JUMP = 0;
         repeat (14) cyc();
         PULSE = 1;
         cyc();
         PULSE = 0;
      end
      cyc();
   endtask

   initial begin
      int spawn_t, over_t, clears;
      bit seen_td;
      RESET = 1; PULSE_EARLY = 0; PULSE = 0; START = 0; JUMP = 0;
      m_reset();
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      RESET = 0;
      chk("rst_state", 32'(STATE), 32'd0);
      chk("rst_obs", 32'(OBSTACLES), 32'd0);
      chk("rst_score", 32'(SCORE), 32'd0);
      chk("rst_air", 32'(AIRBORNE), 32'd0);
      chk("rst_td", 32'(TICK_DONE), 32'd0);
      chk("rst_lfsr", 32'(dut.lfsr), 32'hA5);

      seen_td = 0;
      for (int i = 0; i < 10; i++) begin
         PULSE = 1; cyc(); PULSE = 0; cyc();
         if (TICK_DONE) seen_td = 1;
      end
      chk("idle_state", 32'(STATE), 32'd0);
      chk("idle_obs", 32'(OBSTACLES), 32'd0);
      chk("idle_no_td", 32'(seen_td), 32'd0);

      START = 1; cyc(); START = 0; cyc();
      chk("start_run", 32'(STATE), 32'd1);

      spawn_t = -1; over_t = -1;
      for (int n = 0; n < 300 && over_t < 0; n++) begin
         PULSE_EARLY = 1; cyc(); PULSE_EARLY = 0;
         repeat (14) cyc();
         PULSE = 1; cyc(); PULSE = 0;
         if (STATE == 2'b10) begin
            over_t = n;
            chk("over_td", 32'(TICK_DONE), 32'd1);
         end
         if (spawn_t < 0 && OBSTACLES[15]) spawn_t = n;
         cyc();
      end
      chk("over_reached", 32'(over_t >= 0), 32'd1);
      chk("spawn_to_hit", 32'(over_t - spawn_t), 32'd15);
      chk("over_score", 32'(SCORE), 32'd0);
      chk("over_obs0", 32'(OBSTACLES[0]), 32'd1);

      tick(1'b0, 1'b0);
      chk("over_frozen", 32'(STATE), 32'd2);

      START = 1; PULSE = 1; cyc(); START = 0; PULSE = 0;
      chk("restart_state", 32'(STATE), 32'd1);
      chk("restart_obs", 32'(OBSTACLES), 32'd0);
      chk("restart_no_td", 32'(TICK_DONE), 32'd0);
      cyc();

      tick(1'b1, 1'b1);
      chk("coincide_nojump", 32'(AIRBORNE), 32'd0);

      clears = 0;
      for (int n = 0; n < 400 && clears <= SMAX; n++) begin
         tick(m_obs[2] && m_air == 0, 1'b0);
         if (STATE != 2'b01) begin
            chk("run_unexpected_over", 32'(STATE), 32'd1);
            break;
         end
         if (m_obs[0]) begin
            clears++;
            if (clears == 1) begin
               chk("first_clear", 32'(SCORE), 32'd1);
               chk("first_clear_air", 32'(AIRBORNE), 32'd1);
            end
         end
      end
      chk("clears_done", 32'(clears), 32'(SMAX + 1));
      chk("score_sat", 32'(SCORE), 32'(SMAX));
      chk("sat_state", 32'(STATE), 32'd1);
      chk("air_before_rst", 32'(dut.air), 32'd2);

      #2 RESET = 1;
      #1;
      chk("arst_state", 32'(STATE), 32'd0);
      chk("arst_obs", 32'(OBSTACLES), 32'd0);
      chk("arst_score", 32'(SCORE), 32'd0);
      chk("arst_air", 32'(AIRBORNE), 32'd0);
      chk("arst_td", 32'(TICK_DONE), 32'd0);
      chk("arst_lfsr", 32'(dut.lfsr), 32'hA5);
      @(negedge CLOCK_50);
      RESET = 0;
      m_reset();
      cyc();
      chk("post_rst_state", 32'(STATE), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/game_tick_engine.md
# game_tick_engine

Game-logic stage directly downstream of the game clock divider: consumes its one-cycle game-tick pulse and its early pulse, and advances a side-scrolling "jump the obstacle" lane once per tick. Holds the obstacle row, player airtime, score and the IDLE/RUN/OVER game FSM. Feeds the drawing/display stage with a stable snapshot plus a one-cycle `TICK_DONE` strobe after each update.

## Interface
Parameters:
- `AIR_TICKS`, default 3: number of game ticks the player stays airborne per jump (1..7).
- `MIN_GAP`, default 4: minimum ticks between spawned obstacles; must exceed `AIR_TICKS`.
- `SCORE_MAX`, default 999: score saturation value (fits 10 bits).

Ports:
- `CLOCK_50` input 1: system clock, 50 MHz.
- `RESET` input 1: asynchronous, active-high reset.
- `PULSE_EARLY` input 1: one-cycle strobe from the clock stage, arriving 15 clocks before `PULSE`.
- `PULSE` input 1: one-cycle game-tick strobe.
- `START` input 1: start/restart button, active-high level, already synchronised.
- `JUMP` input 1: jump button, active-high level, already synchronised.
- `OBSTACLES` output 16: obstacle row; bit 15 is the spawn column, bit 0 is the player column.
- `AIRBORNE` output 1: player is in the air.
- `SCORE` output 10: obstacles cleared, saturating.
- `STATE` output 2: 00 IDLE, 01 RUN, 10 OVER.
- `TICK_DONE` output 1: one-cycle strobe, the cycle after a RUN tick is committed.

## Operation
- FSM states:
  - IDLE: all game registers are held at zero.
  - RUN: the game advances on each `PULSE`.
  - OVER: `OBSTACLES`, `SCORE` and `AIRBORNE` are frozen at the collision values.
- START rising-edge detector: `start_q` is registered each cycle; edge = `START & ~start_q`.
- Transitions:
  - IDLE --edge--> RUN.
  - OVER --edge--> RUN.
  - RUN --collision--> OVER.
  - Entering RUN clears obstacles, score, air counter, gap counter and jump request. The LFSR is not reseeded.
- Jump request `jreq`:
  - In RUN, on `PULSE_EARLY` with `JUMP`=1, `jreq` is set.
  - `jreq` is cleared on every `PULSE` and on entering RUN.
  - `JUMP` is ignored outside `PULSE_EARLY` cycles.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset. It steps once per RUN `PULSE`.
- Gap counter `gap`: 4-bit, saturates at 15.
- Per RUN `PULSE`, computed from current register values:
  - `spawn` = (lfsr[2:0]==0) && (gap >= MIN_GAP).
  - `gap_n` = spawn ? 0 : sat(gap+1).
  - `obs_n` = {spawn, OBSTACLES[15:1]}.
  - `air_n`: if `air`==0 and `jreq`, then `AIR_TICKS`; else if `air`>0, then `air`-1; else 0.
  - Collision = `obs_n[0]` && `air_n`==0. On collision, commit `obs_n` and `air_n`, score unchanged, go to OVER.
  - Clear = `obs_n[0]` && `air_n`!=0. On clear, `SCORE` = min(`SCORE`+1, `SCORE_MAX`).
- `AIRBORNE` = (`air` != 0).

## Timing
- Reset values: `OBSTACLES`=0, `AIRBORNE`=0, `SCORE`=0, `STATE`=IDLE, `TICK_DONE`=0, lfsr=8'hA5, `gap`=0, `air`=0, `jreq`=0, `start_q`=0.
- Latency: state registers update on the clock edge where `PULSE`=1. `TICK_DONE` is high exactly the following cycle, in RUN and also on the tick that enters OVER.
- `PULSE` in IDLE or OVER has no effect and produces no `TICK_DONE`.
- START edge and `PULSE` in the same cycle (IDLE/OVER): only the transition happens; that tick is dropped.
- START edge while in RUN: ignored.
- `PULSE_EARLY` and `PULSE` in the same cycle: the `PULSE` uses the old `jreq`, then clears it. The early sample is lost.
- `PULSE` without a preceding `PULSE_EARLY`: no jump.
- A jump request while already airborne is discarded at the tick; there is no buffering.
- Reset asserted mid-game: all registers go to their reset values immediately, without waiting for a clock edge.

## Test plan
- Reset then 10 `PULSE`s without START: `STATE`=00, `OBSTACLES`=0, `TICK_DONE` never asserts.
- START edge, then run ticks with `JUMP`=0: the first spawn appears at bit 15 on the first tick where lfsr[2:0]==0 and `gap`>=4. It reaches bit 0 15 ticks later, then `STATE`=10 and `SCORE`=0, with one final `TICK_DONE`.
- Obstacle at bit 2 with `JUMP` high on the `PULSE_EARLY` before that tick: `AIRBORNE`=1 for 3 ticks, the obstacle passes bit 0, `SCORE` increments 0->1, `STATE` stays 01.
- Force score to 999 via repeated clears: the next clear keeps `SCORE`=999.
- `PULSE_EARLY` and `PULSE` coincident with `JUMP`=1 and `jreq`=0: no jump. Separately, a START edge in OVER coincident with `PULSE`: `STATE`=01, all cleared, no `TICK_DONE`.
- Assert `RESET` for 1 cycle mid-RUN with `SCORE`=5 and `air`=2: all outputs read zero/IDLE asynchronously, and lfsr reads 8'hA5.
